// File: rtl/voice_allocator.sv
// Voice allocator: maps a note-on/note-off event stream onto register-bank channels and sweeps them on each sample tick.
// Optional voice stealing when all channels are busy is enabled with `define VOICE_STEAL_EN.
module voice_allocator #(
    parameter int NUM_BITS_IN  = 18,
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS_KEY = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    evt_valid,
    output logic                    evt_ready,
    input  logic                    evt_on,
    input  logic [NUM_BITS_KEY-1:0] evt_key,
    input  logic [NUM_BITS_IN-1:0]  evt_word,
    input  logic [NUM_CHANNELS-1:0] available,
    output logic [NUM_CHANNELS-1:0] reg_en,
    output logic [NUM_CHANNELS-1:0] note_en,
    output logic [NUM_BITS_IN-1:0]  note_in,
    output logic                    evt_drop,
    output logic                    overrun
);

    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, EVENT} state_t;

    state_t                    state, state_next;
    logic [CW-1:0]             cnt, cnt_next;
    logic [NUM_BITS_KEY-1:0]   key_tab  [NUM_CHANNELS];
    logic [NUM_BITS_IN-1:0]    word_tab [NUM_CHANNELS];
    logic                      on_q;
    logic [NUM_BITS_KEY-1:0]   key_q;
    logic [NUM_BITS_IN-1:0]    word_q;
    logic [NUM_CHANNELS-1:0]   reg_en_next;
    logic [NUM_BITS_IN-1:0]    note_in_next;
    logic                      overrun_next;
    logic                      accept;
    logic [NUM_CHANNELS-1:0]   match_vec;
    logic [NUM_CHANNELS-1:0]   free_vec;
    logic                      match_any;
    logic                      free_any;
    logic [CW-1:0]             match_idx;
    logic [CW-1:0]             free_idx;

    assign evt_ready = (state == IDLE) && !sample_tick;
    assign accept    = evt_valid && evt_ready;

    // A channel counts as busy while note_en is set, even before the bank reports it busy.
    always_comb begin
        match_vec = '0;
        match_idx = '0;
        free_idx  = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            match_vec[k] = note_en[k] && (key_tab[k] == key_q);
        end
        free_vec = available & ~note_en;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (match_vec[k]) match_idx = CW'(k);
            if (free_vec[k])  free_idx  = CW'(k);
        end
    end

    assign match_any = |match_vec;
    assign free_any  = |free_vec;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        reg_en_next  = '0;
        note_in_next = note_in;
        overrun_next = overrun;
        unique case (state)
            IDLE: begin
                if (sample_tick) begin
                    state_next   = SWEEP;
                    cnt_next     = '0;
                    reg_en_next  = {{(NUM_CHANNELS-1){1'b0}}, 1'b1};
                    note_in_next = word_tab[0];
                end else if (accept) begin
                    state_next = EVENT;
                end
            end
            SWEEP: begin
                if (sample_tick) overrun_next = 1'b1;
                if (cnt == LAST_CH) begin
                    state_next = IDLE;
                end else begin
                    cnt_next     = cnt + 1'b1;
                    reg_en_next  = reg_en << 1;
                    note_in_next = word_tab[cnt_next];
                end
            end
            EVENT: begin
                // A tick landing on the event cycle still starts a sweep rather than being lost.
                if (sample_tick) begin
                    state_next   = SWEEP;
                    cnt_next     = '0;
                    reg_en_next  = {{(NUM_CHANNELS-1){1'b0}}, 1'b1};
                    note_in_next = word_tab[0];
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            reg_en  <= '0;
            note_in <= '0;
            overrun <= 1'b0;
            on_q    <= 1'b0;
            key_q   <= '0;
            word_q  <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            reg_en  <= reg_en_next;
            note_in <= note_in_next;
            overrun <= overrun_next;
            if (accept) begin
                on_q   <= evt_on;
                key_q  <= evt_key;
                word_q <= evt_word;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [CW-1:0] steal_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                key_tab[k]  <= '0;
                word_tab[k] <= '0;
            end
            note_en  <= '0;
            evt_drop <= 1'b0;
`ifdef VOICE_STEAL_EN
            steal_ptr <= '0;
`endif
        end else begin
            evt_drop <= 1'b0;
            if (state == EVENT) begin
                if (on_q) begin
                    if (match_any) begin
                        word_tab[match_idx] <= word_q;
                    end else if (free_any) begin
                        key_tab[free_idx]  <= key_q;
                        word_tab[free_idx] <= word_q;
                        note_en[free_idx]  <= 1'b1;
                    end else begin
`ifdef VOICE_STEAL_EN
                        key_tab[steal_ptr]  <= key_q;
                        word_tab[steal_ptr] <= word_q;
                        note_en[steal_ptr]  <= 1'b1;
                        steal_ptr <= (steal_ptr == LAST_CH) ? '0 : steal_ptr + 1'b1;
`else
                        evt_drop <= 1'b1;
`endif
                    end
                end else if (match_any) begin
                    note_en[match_idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard testbench for voice_allocator; sweep strobes are predicted from a bench-side channel model.
// Honors VOICE_STEAL_EN the same way as the design.
module tb_voice_allocator;

    localparam int N = 16;
    localparam int W = 18;
    localparam int K = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample_tick;
    logic         evt_valid;
    logic         evt_ready;
    logic         evt_on;
    logic [K-1:0] evt_key;
    logic [W-1:0] evt_word;
    logic [N-1:0] available;
    logic [N-1:0] reg_en;
    logic [N-1:0] note_en;
    logic [W-1:0] note_in;
    logic         evt_drop;
    logic         overrun;

    int checkCount = 0;
    int errCount   = 0;
    int lastWait   = 0;

    logic [N+W-1:0] sbq [$];

    logic [K-1:0] mKey  [N];
    logic [W-1:0] mWord [N];
    logic [N-1:0] mEn;
    int           mPtr;

    voice_allocator #(.NUM_BITS_IN(W), .NUM_CHANNELS(N), .NUM_BITS_KEY(K)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_on(evt_on),
        .evt_key(evt_key), .evt_word(evt_word), .available(available),
        .reg_en(reg_en), .note_en(note_en), .note_in(note_in),
        .evt_drop(evt_drop), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < N; i++) begin
            mKey[i]  = '0;
            mWord[i] = '0;
        end
        mEn  = '0;
        mPtr = 0;
    endtask

    task automatic modelEvent(input bit on, input logic [K-1:0] k, input logic [W-1:0] w, output bit drop);
        int hit = -1;
        int fr  = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (mEn[i] && mKey[i] == k) hit = i;
            if (available[i] && !mEn[i]) fr = i;
        end
        drop = 1'b0;
        if (on) begin
            if (hit >= 0) begin
                mWord[hit] = w;
            end else if (fr >= 0) begin
                mKey[fr] = k; mWord[fr] = w; mEn[fr] = 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
                mKey[mPtr] = k; mWord[mPtr] = w; mEn[mPtr] = 1'b1;
                mPtr = (mPtr + 1) % N;
`else
                drop = 1'b1;
`endif
            end
        end else if (hit >= 0) begin
            mEn[hit] = 1'b0;
        end
    endtask

    task automatic pushSweep();
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) begin
            oh = N'(1) << i;
            sbq.push_back({oh, mWord[i]});
        end
    endtask

    // Every nonzero strobe must match the next predicted {reg_en, note_in} pair.
    always @(negedge clk) begin
        logic [N+W-1:0] exp;
        if (!rst && reg_en != '0) begin
            if (sbq.size() == 0) begin
                checkOutput("sweep_extra", 64'(reg_en), 64'd0);
            end else begin
                exp = sbq.pop_front();
                checkOutput("sweep_strobe", 64'({reg_en, note_in}), 64'(exp));
            end
        end
    end

    task automatic doSweep(input int extraTickAt);
        int n = 0;
        @(negedge clk);
        sample_tick = 1'b1;
        pushSweep();
        @(negedge clk);
        sample_tick = 1'b0;
        if (extraTickAt > 0) begin
            repeat (extraTickAt - 1) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("sweep_done", 64'(sbq.size()), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("sweep_idle", 64'(reg_en), 64'd0);
        checkOutput("sweep_hold", 64'(note_in), 64'(mWord[N-1]));
    endtask

    task automatic applyStimulus(input bit on, input logic [K-1:0] k, input logic [W-1:0] w, input bit withTick);
        int  n = 0;
        bit  ok = 1'b0;
        bit  expDrop;
        @(negedge clk);
        evt_valid = 1'b1;
        evt_on    = on;
        evt_key   = k;
        evt_word  = w;
        if (withTick) begin
            sample_tick = 1'b1;
            pushSweep();
        end
        lastWait = 0;
        while (!ok && n < 60) begin
            #1;
            if (evt_ready) begin
                ok = 1'b1;
            end else begin
                lastWait++;
                @(negedge clk);
                sample_tick = 1'b0;
                n++;
            end
        end
        if (!ok) begin
            checkOutput("evt_timeout", 64'd0, 64'd1);
            evt_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        evt_valid = 1'b0;
        modelEvent(on, k, w, expDrop);
        @(negedge clk);
        checkOutput("note_en", 64'(note_en), 64'(mEn));
        checkOutput("evt_drop", 64'(evt_drop), 64'(expDrop));
    endtask

    initial begin
        rst = 1'b1;
        sample_tick = 1'b0;
        evt_valid = 1'b0;
        evt_on = 1'b0;
        evt_key = '0;
        evt_word = '0;
        available = '1;
        modelClear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_reg_en", 64'(reg_en), 64'd0);
        checkOutput("rst_note_en", 64'(note_en), 64'd0);
        checkOutput("rst_note_in", 64'(note_in), 64'd0);
        checkOutput("rst_drop", 64'(evt_drop), 64'd0);
        checkOutput("rst_overrun", 64'(overrun), 64'd0);
        checkOutput("rst_ready", 64'(evt_ready), 64'd1);

        doSweep(0);
        checkOutput("overrun_clear", 64'(overrun), 64'd0);

        applyStimulus(1'b1, 7'd60, 18'h12345, 1'b0);
        applyStimulus(1'b1, 7'd64, 18'h00ABC, 1'b0);
        doSweep(0);

        applyStimulus(1'b0, 7'd60, '0, 1'b0);
        applyStimulus(1'b0, 7'd99, '0, 1'b0);

        applyStimulus(1'b1, 7'd62, 18'h3C3C3, 1'b1);
        checkOutput("tick_block_cycles", 64'(lastWait), 64'd17);
        checkOutput("tick_block_sweep", 64'(sbq.size()), 64'd0);

        applyStimulus(1'b1, 7'd64, 18'h2AAAA, 1'b0);

        doSweep(5);
        checkOutput("overrun_set", 64'(overrun), 64'd1);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 7'(80 + i), 18'(20'h01000 + i * 20'h111), 1'b0);
        end
        checkOutput("full", 64'(note_en), 64'hFFFF);
        applyStimulus(1'b1, 7'd70, 18'h1F0F0, 1'b0);
        applyStimulus(1'b1, 7'd71, 18'h0F0F1, 1'b0);
        doSweep(0);
        applyStimulus(1'b0, 7'd70, '0, 1'b0);
        checkOutput("overrun_sticky", 64'(overrun), 64'd1);

        // Reset in the middle of a sweep: strobes must stop at once.
        @(negedge clk);
        sample_tick = 1'b1;
        pushSweep();
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        sbq.delete();
        modelClear();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_reg_en", 64'(reg_en), 64'd0);
        checkOutput("midrst_note_en", 64'(note_en), 64'd0);
        checkOutput("midrst_overrun", 64'(overrun), 64'd0);

        available = 16'hFFFC;
        applyStimulus(1'b1, 7'd5, 18'h00777, 1'b0);
        checkOutput("avail_mask", 64'(note_en), 64'h0004);
        doSweep(0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
